word_aes_round_engine: RTL and testbench

//  Multi-cycle AES encryption round engine on a full 128-bit state with valid/ready handshakes.

---
 rtl/word_aes_round_engine.sv | 178 +++++++++++++++++
 tb/tb_word_aes_round_engine.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/word_aes_round_engine.sv
// AES encryption round engine: SubBytes, ShiftRows, MixColumns (skipped on the
// last round) and AddRoundKey over a 128-bit state, COLS_PER_CYCLE columns per clock.
// Build option: define OUT_REG_EN to add a flop stage (FLUSH state) in front of state_out.
module word_aes_round_engine #(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         last_round,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   localparam int unsigned BEATS  = (COLS_PER_CYCLE == 4) ? 1 : (COLS_PER_CYCLE == 2) ? 2 : 4;
   localparam int unsigned BEAT_W = 2;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BUSY  = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
`ifdef OUT_REG_EN
   localparam logic [1:0] S_FLUSH = 2'd3;
`endif

   // Forward S-box, row-major, entry 0x00 at the MSB end
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Reject unsupported column widths at elaboration
   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
         $error("word_aes_round_engine: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[11'(2047 - 8 * int'(x)) -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] get_byte(input logic [127:0] st, input logic [1:0] c,
                                           input logic [1:0] r);
      return st[7'(127 - 32 * int'(c) - 8 * int'(r)) -: 8];
   endfunction

   // One output column: shifted bytes -> S-box -> optional MixColumns -> key XOR
   function automatic logic [31:0] round_col(input logic [127:0] st, input logic [127:0] key,
                                             input logic last, input logic [1:0] c);
      logic [7:0]  s0, s1, s2, s3;
      logic [31:0] mix;
      s0  = sbox(get_byte(st, c,         2'd0));
      s1  = sbox(get_byte(st, c + 2'd1,  2'd1));
      s2  = sbox(get_byte(st, c + 2'd2,  2'd2));
      s3  = sbox(get_byte(st, c + 2'd3,  2'd3));
      if (last) begin
         mix = {s0, s1, s2, s3};
      end else begin
         mix = {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
                s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
                s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
                xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
      end
      return mix ^ key[7'(127 - 32 * int'(c)) -: 32];
   endfunction

   logic [1:0]        state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [127:0]      lat_state_q, lat_key_q;
   logic              lat_last_q;
   logic [127:0]      hold_q, hold_d;
   logic              latch_en, hold_en;

   // Next-state and beat sequencing
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      latch_en = 1'b0;
      hold_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               latch_en = 1'b1;
               beat_d   = '0;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            hold_en = 1'b1;
            if (beat_q == LAST_BEAT) begin
               beat_d  = '0;
`ifdef OUT_REG_EN
               state_d = S_FLUSH;
`else
               state_d = S_DONE;
`endif
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
`ifdef OUT_REG_EN
         S_FLUSH: state_d = S_DONE;
`endif
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Columns of the current beat merged into the holding register image
   always_comb begin
      hold_d = hold_q;
      for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
         hold_d[7'(127 - 32 * (int'(beat_q) * int'(COLS_PER_CYCLE) + k)) -: 32] =
            round_col(lat_state_q, lat_key_q, lat_last_q,
                      2'(int'(beat_q) * int'(COLS_PER_CYCLE) + k));
      end
   end

   // State, counters, latched round inputs, holding register and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         lat_state_q <= '0;
         lat_key_q   <= '0;
         lat_last_q  <= 1'b0;
         hold_q      <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         in_ready  <= (state_d == S_IDLE);
         out_valid <= (state_d == S_DONE);
         busy      <= (state_d == S_BUSY);
         if (latch_en) begin
            lat_state_q <= state_in;
            lat_key_q   <= round_key;
            lat_last_q  <= last_round;
         end
         if (hold_en) hold_q <= hold_d;
      end
   end

`ifdef OUT_REG_EN
   logic [127:0] out_q;

   // Output stage loaded from the completed holding register during FLUSH
   always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else if (state_q == S_FLUSH) out_q <= hold_q;
   end

   assign state_out = out_q;
`else
   assign state_out = hold_q;
`endif

endmodule

// File: tb/tb_word_aes_round_engine.sv
// Self-checking bench: three engines (1, 2 and 4 columns per clock) run in lockstep
// against a GF(2^8) arithmetic reference of the AES round.
module tb_word_aes_round_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, in_valid, last_round, out_ready;
   logic [127:0] state_in, round_key;
   logic [2:0]   in_ready, out_valid, busy;
   logic [127:0] state_out [3];

   int n_tests = 0;
   int n_fail  = 0;

`ifdef OUT_REG_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   localparam logic [127:0] T1_ST  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] T1_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] T1_EXP = 128'ha49c7ff2689f352b6b5bea43026a5049;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         word_aes_round_engine #(.COLS_PER_CYCLE(32'(1 << gi))) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready[gi]),
            .state_in   (state_in),
            .round_key  (round_key),
            .last_round (last_round),
            .out_valid  (out_valid[gi]),
            .out_ready  (out_ready),
            .state_out  (state_out[gi]),
            .busy       (busy[gi])
         );
      end
   endgenerate

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference arithmetic
   logic [7:0] sb_tab [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? (8'({x, 1'b0}) ^ 8'h1b) : 8'({x, 1'b0});
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] getb(input logic [127:0] v, input int c, input int r);
      return 8'(v >> (120 - 32 * c - 8 * r));
   endfunction

   function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                              input logic last);
      logic [127:0] t, o;
      logic [7:0]   b;
      t = '0;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t = t | (128'(sb_tab[getb(st, (c + r) % 4, r)]) << (120 - 32 * c - 8 * r));
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            if (last) b = getb(t, c, r);
            else b = gmul(8'h02, getb(t, c, r)) ^ gmul(8'h03, getb(t, c, (r + 1) % 4))
                     ^ getb(t, c, (r + 2) % 4) ^ getb(t, c, (r + 3) % 4);
            o = o | (128'(b ^ getb(key, c, r)) << (120 - 32 * c - 8 * r));
         end
      return o;
   endfunction

   task automatic drive_junk();
      in_valid   = 1'($urandom_range(0, 1));
      state_in   = {$urandom, $urandom, $urandom, $urandom};
      round_key  = {$urandom, $urandom, $urandom, $urandom};
      last_round = 1'($urandom_range(0, 1));
   endtask

   // One round through all engines; entered and left at a falling edge
   task automatic do_round(input logic [127:0] st, input logic [127:0] key, input logic last,
                           input logic [127:0] exp, input int hold, input string tag);
      int         lat [3];
      logic [2:0] seen;
      int         j;
      seen = '0;
      for (int i = 0; i < 3; i++) lat[i] = 0;
      in_valid = 1'b1; state_in = st; round_key = key; last_round = last; out_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         check_eq({tag, "/accept_rdy_busy"}, 128'({in_ready[i], busy[i]}), 128'(2'b01));
      j = 0;
      while (seen != 3'b111 && j < 20) begin
         drive_junk();
         @(negedge clk);
         j++;
         for (int i = 0; i < 3; i++)
            if (!seen[i] && out_valid[i]) begin
               seen[i] = 1'b1;
               lat[i]  = j;
            end
      end
      for (int i = 0; i < 3; i++) begin
         check_eq({tag, "/latency"}, 128'(lat[i]), 128'((4 >> i) + EXTRA));
         check_eq({tag, "/state_out"}, state_out[i], exp);
      end
      repeat (hold) begin
         drive_junk();
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            check_eq({tag, "/hold_vld_rdy"}, 128'({out_valid[i], in_ready[i]}), 128'(2'b10));
            check_eq({tag, "/hold_data"}, state_out[i], exp);
         end
      end
      in_valid = 1'b1; state_in = {$urandom, $urandom, $urandom, $urandom}; out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         check_eq({tag, "/post_handshake"}, 128'({in_ready[i], out_valid[i], busy[i]}),
                  128'(3'b100));
      in_valid = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      logic [127:0] st, key;
      logic         last;
      for (int i = 0; i < 256; i++) sb_tab[i] = sbox_ref(8'(i));
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; last_round = 1'b0;
      state_in = '0; round_key = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("reset_flags", 128'({in_ready[i], out_valid[i], busy[i]}), 128'(3'b100));
         check_eq("reset_data", state_out[i], 128'h0);
      end

      do_round(T1_ST, T1_KEY, 1'b0, T1_EXP, 0, "fips_r1");
      do_round(128'h0, 128'h0, 1'b1, {16{8'h63}}, 1, "zero_last");
      do_round(128'h0, {128{1'b1}}, 1'b1, {16{8'h9c}}, 0, "ones_key_last");
      do_round(T1_ST, T1_KEY, 1'b0, T1_EXP, 10, "backpressure");

      // Reset while the 1-column engine sits at beat 1
      in_valid = 1'b1; state_in = T1_ST; round_key = T1_KEY; last_round = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("midrst_flags", 128'({in_ready[i], out_valid[i], busy[i]}), 128'(3'b100));
         check_eq("midrst_data", state_out[i], 128'h0);
      end
      do_round(T1_ST, T1_KEY, 1'b0, T1_EXP, 0, "after_rst");

      for (int n = 0; n < 30; n++) begin
         st   = {$urandom, $urandom, $urandom, $urandom};
         key  = {$urandom, $urandom, $urandom, $urandom};
         last = 1'($urandom_range(0, 1));
         do_round(st, key, last, ref_round(st, key, last), $urandom_range(0, 2), "random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
